// File: rtl/ripple_down_counter_if.sv
`default_nettype none
// ============================================================================
// ripple_down_counter_if : control/status bundle for the ripple down-counter
// Rev 1.0
// ============================================================================
interface ripple_down_counter_if;
    logic       in_enable;
    logic       in_load;
    logic [7:0] in_load_value;
    logic       in_auto_reload;
    logic [7:0] out_value;
    logic       out_zero;
    logic       out_terminal;
    logic [1:0] out_state;

    modport master (
        output in_enable,
        output in_load,
        output in_load_value,
        output in_auto_reload,
        input  out_value,
        input  out_zero,
        input  out_terminal,
        input  out_state
    );

    modport slave (
        input  in_enable,
        input  in_load,
        input  in_load_value,
        input  in_auto_reload,
        output out_value,
        output out_zero,
        output out_terminal,
        output out_state
    );
endinterface
`default_nettype wire

// File: rtl/ripple_down_counter.sv
`default_nettype none
// ============================================================================
// ripple_down_counter : 8-bit loadable down-counter, one-shot or periodic,
//                       decrement built from a ripple chain of full adders
// Rev 1.0
// ============================================================================
module rdc_full_adder (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_ci,
    output logic      o_s,
    output logic      o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module ripple_down_counter (
    input  wire logic             in_clock,
    input  wire logic             in_reset,
    ripple_down_counter_if.slave  bus
);
    localparam logic [1:0] c_st_idle = 2'b00;
    localparam logic [1:0] c_st_run  = 2'b01;
    localparam logic [1:0] c_st_halt = 2'b10;
    localparam logic [7:0] c_minus_one = 8'hFF;

    logic [1:0] r_state;
    logic [7:0] r_value;
    logic [7:0] r_reload;
    logic       r_terminal;

    logic [1:0] w_next_state;
    logic [7:0] w_next_value;
    logic [7:0] w_next_reload;
    logic       w_next_terminal;

    logic [7:0] w_dec;
    logic [8:0] w_carry;
    logic       w_unused_carry;

    // value - 1 as value + 8'hFF; the final carry-out is intentionally dropped
    assign w_carry[0] = 1'b0;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_ripple
            rdc_full_adder u_fa (
                .i_a  (r_value[g]),
                .i_b  (c_minus_one[g]),
                .i_ci (w_carry[g]),
                .o_s  (w_dec[g]),
                .o_co (w_carry[g+1])
            );
        end
    endgenerate

    assign w_unused_carry = w_carry[8];

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_state    <= c_st_idle;
            r_value    <= 8'h00;
            r_reload   <= 8'h00;
            r_terminal <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_value    <= w_next_value;
            r_reload   <= w_next_reload;
            r_terminal <= w_next_terminal;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_value    = r_value;
        w_next_reload   = r_reload;
        w_next_terminal = 1'b0;
        if (bus.in_load) begin
            // a load wins over any decrement, reload or terminal event
            w_next_reload = bus.in_load_value;
            w_next_value  = bus.in_load_value;
            w_next_state  = (bus.in_load_value == 8'h00) ? c_st_halt : c_st_run;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (bus.in_enable) begin
                        if (r_value == 8'h00) begin
                            if (bus.in_auto_reload) begin
                                w_next_value = r_reload;
                            end else begin
                                w_next_state = c_st_halt;
                            end
                        end else if (r_value == 8'h01) begin
                            w_next_value    = w_dec;
                            w_next_terminal = 1'b1;
                            w_next_state    = bus.in_auto_reload ? c_st_run : c_st_halt;
                        end else begin
                            w_next_value = w_dec;
                        end
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    always_comb begin
        bus.out_value    = r_value;
        bus.out_zero     = (r_value == 8'h00);
        bus.out_terminal = r_terminal;
        bus.out_state    = r_state;
    end
endmodule
`default_nettype wire

// File: tb/tb_ripple_down_counter.sv
`default_nettype none
// ============================================================================
// tb_ripple_down_counter : directed vector bench for ripple_down_counter
// Rev 1.0
// ============================================================================
module tb_ripple_down_counter;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HALT = 2'b10;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       ar;
        logic [7:0] exp_value;
        logic [1:0] exp_state;
        logic       exp_term;
        logic       exp_zero;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    ripple_down_counter_if bus();

    ripple_down_counter dut (
        .in_clock (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [7:0] lv, input logic en, input logic ar);
        @(negedge clk);
        rst                = r;
        bus.in_load        = ld;
        bus.in_load_value  = lv;
        bus.in_enable      = en;
        bus.in_auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic ld, input logic [7:0] lv, input logic en,
                                input logic ar, input logic [7:0] v, input logic [1:0] s, input logic t);
        vec_t x;
        x.rst = r; x.ld = ld; x.lv = lv; x.en = en; x.ar = ar;
        x.exp_value = v; x.exp_state = s; x.exp_term = t; x.exp_zero = (v == 8'h00);
        vecs.push_back(x);
    endfunction

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.in_load = 1'b0; bus.in_load_value = 8'h00; bus.in_enable = 1'b0; bus.in_auto_reload = 1'b0;

        //  rst ld  lv     en ar   value  state term
        add(1, 0, 8'h00, 0, 0,   8'h00, IDLE, 0);   // reset
        for (int i = 0; i < 5; i++)
            add(0, 0, 8'h00, 1, 0, 8'h00, IDLE, 0); // enable without load is ignored
        add(0, 1, 8'h03, 0, 0,   8'h03, RUN,  0);   // one-shot from 3
        add(0, 0, 8'h00, 1, 0,   8'h02, RUN,  0);
        add(0, 0, 8'h00, 1, 0,   8'h01, RUN,  0);
        add(0, 0, 8'h00, 1, 0,   8'h00, HALT, 1);
        add(0, 0, 8'h00, 1, 0,   8'h00, HALT, 0);
        add(0, 0, 8'h00, 1, 0,   8'h00, HALT, 0);
        add(0, 1, 8'h02, 0, 1,   8'h02, RUN,  0);   // periodic from 2
        for (int p = 0; p < 3; p++) begin
            add(0, 0, 8'h00, 1, 1, 8'h01, RUN, 0);
            add(0, 0, 8'h00, 1, 1, 8'h00, RUN, 1);
            if (p < 2) add(0, 0, 8'h00, 1, 1, 8'h02, RUN, 0);
        end
        add(0, 0, 8'h00, 0, 1,   8'h00, RUN,  0);   // disabled: hold
        add(0, 0, 8'h00, 1, 0,   8'h00, HALT, 0);   // auto-reload dropped at 0
        add(0, 1, 8'h01, 0, 0,   8'h01, RUN,  0);   // load overrides 1->0
        add(0, 1, 8'h80, 1, 0,   8'h80, RUN,  0);
        add(0, 0, 8'h00, 0, 0,   8'h80, RUN,  0);
        add(0, 1, 8'h05, 0, 0,   8'h05, RUN,  0);   // reset beats load+enable
        add(0, 0, 8'h00, 1, 0,   8'h04, RUN,  0);
        add(0, 0, 8'h00, 1, 0,   8'h03, RUN,  0);
        add(1, 1, 8'h09, 1, 0,   8'h00, IDLE, 0);
        add(0, 0, 8'h00, 1, 1,   8'h00, IDLE, 0);
        add(0, 1, 8'h00, 1, 1,   8'h00, HALT, 0);   // loading zero never pulses
        add(0, 0, 8'h00, 1, 1,   8'h00, HALT, 0);
        add(0, 1, 8'h01, 0, 1,   8'h01, RUN,  0);   // periodic reload of 1
        add(0, 0, 8'h00, 1, 1,   8'h00, RUN,  1);
        add(0, 0, 8'h00, 1, 1,   8'h01, RUN,  0);
        add(0, 1, 8'h07, 1, 1,   8'h07, RUN,  0);   // load suppresses pulse
        add(0, 0, 8'h00, 1, 1,   8'h06, RUN,  0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
            chk("value",    i, bus.out_value,           vecs[i].exp_value);
            chk("state",    i, {6'd0, bus.out_state},   {6'd0, vecs[i].exp_state});
            chk("terminal", i, {7'd0, bus.out_terminal}, {7'd0, vecs[i].exp_term});
            chk("zero",     i, {7'd0, bus.out_zero},    {7'd0, vecs[i].exp_zero});
        end

        // full-range one-shot count from 8'hFF
        drive(0, 1, 8'hFF, 0, 0);
        chk("ff_load", 0, bus.out_value, 8'hFF);
        pulses = 0;
        for (int i = 1; i <= 255; i++) begin
            logic [7:0] exp_v;
            exp_v = 8'(255 - i);
            drive(0, 0, 8'h00, 1, 0);
            chk("ff_value", i, bus.out_value, exp_v);
            if (bus.out_terminal) pulses++;
        end
        chk("ff_term_last", 255, {7'd0, bus.out_terminal}, 8'h01);
        chk("ff_state", 255, {6'd0, bus.out_state}, {6'd0, HALT});
        drive(0, 0, 8'h00, 1, 0);
        chk("ff_hold", 256, bus.out_value, 8'h00);
        if (bus.out_terminal) pulses++;
        chk("ff_pulses", 256, 8'(pulses), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ripple_down_counter.md
RIPPLE_DOWN_COUNTER -- requirements
Module: ripple_down_counter

Interface
REQ-001 The block SHALL have in_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have in_reset, input, 1 bit: synchronous, active-high reset, sampled on the in_clock rising edge.
REQ-003 The block SHALL have in_enable, input, 1 bit: count-step request, one decrement per enabled cycle.
REQ-004 The block SHALL have in_load, input, 1 bit: load strobe.
REQ-005 The block SHALL have in_load_value, input, 8 bits: start value captured on load.
REQ-006 The block SHALL have in_auto_reload, input, 1 bit: 1 selects periodic mode, 0 selects one-shot mode; sampled every cycle.
REQ-007 The block SHALL have out_value, output, 8 bits: current count, driven directly from the count register.
REQ-008 The block SHALL have out_zero, output, 1 bit: combinational, high when out_value == 8'h00.
REQ-009 The block SHALL have out_terminal, output, 1 bit: registered, one-cycle pulse on terminal count.
REQ-010 The block SHALL have out_state, output, 2 bits: current FSM state, encoded IDLE=2'b00, RUN=2'b01, HALT=2'b10.

Function
REQ-011 Decrement SHALL be computed as value + 8'hFF through an 8-stage ripple chain of the team's full-adder cell, with stage 0 carry-in 0 and carry-out discarded; no behavioural "-" operator on the count path.
REQ-012 The block SHALL hold an 8-bit reload register, written with in_load_value on every accepted load.
REQ-013 Priority per edge SHALL be: in_reset > in_load > in_enable.
REQ-014 In IDLE, in_enable SHALL be ignored and the value held; in_load SHALL set value = in_load_value and go to RUN, or go to HALT if in_load_value == 0.
REQ-015 In RUN with in_enable=1 and value >= 2, value SHALL become value-1 and the state SHALL remain RUN.
REQ-016 In RUN with in_enable=1 and value == 1, value SHALL become 0 and out_terminal SHALL be 1 on the following cycle only. The next state SHALL be HALT if in_auto_reload=0, or RUN if in_auto_reload=1.
REQ-017 In RUN with in_enable=1 and value == 0 (periodic mode only), value SHALL become the reload register; out_terminal SHALL not pulse.
REQ-018 Periodic mode SHALL therefore repeat with period N+1 enabled cycles for loaded value N, with exactly one out_terminal pulse per period.
REQ-019 In RUN with in_enable=0, value and state SHALL hold and out_terminal SHALL be 0.
REQ-020 If in_auto_reload falls while in RUN at value 0, the next enabled cycle SHALL go to HALT with value held at 0 and no pulse.
REQ-021 In HALT, in_enable SHALL be ignored and value held at 0; in_load SHALL behave as in IDLE.
REQ-022 A load in RUN SHALL override any concurrent decrement, reload or terminal event, and SHALL suppress that cycle's out_terminal pulse.
REQ-023 Loading 8'h00 SHALL never generate out_terminal.
REQ-024 out_terminal SHALL be 0 in every cycle not covered by REQ-016.

Reset
REQ-025 On in_reset=1 at an edge: value = 8'h00, reload register = 8'h00, state = IDLE, out_terminal = 0; out_zero therefore reads 1.
REQ-026 Reset asserted mid-count SHALL abort the count on that edge, irrespective of in_load and in_enable.
REQ-027 After reset, counting SHALL not resume until a load is accepted.

Verification
REQ-028 Reset, then in_enable=1 for 5 cycles without a load -> out_value stays 8'h00, out_state=IDLE, out_zero=1, no out_terminal.
REQ-029 Load 8'h03 in one-shot mode, then enable continuously -> out_value 3,2,1,0; one out_terminal pulse the cycle after 0 is reached; out_state=HALT; further enables keep 0.
REQ-030 Load 8'h02 in periodic mode, enable continuously for 9 cycles -> out_value 2,1,0,2,1,0,2,1,0; an out_terminal pulse after each 1->0 step; state stays RUN.
REQ-031 Load 8'h01, then assert in_load with 8'h80 on the same edge as the 1->0 decrement -> out_value=8'h80, no out_terminal pulse, state RUN.
REQ-032 Load 8'hFF, enable 255 cycles in one-shot mode -> ripple chain reaches 0 correctly with every intermediate value exact; one pulse.
REQ-033 Load 8'h05, enable 2 cycles, assert in_reset together with in_load and in_enable -> out_value=0, out_state=IDLE, out_terminal=0.
